// File: rtl/jt900h_ramwr.sv
// CPU write path to 16-bit RAM: splits a byte/word/long write at any byte
// address into halfword or single-lane accesses, TLCS-900 little-endian lanes.
module jt900h_ramwr #(
  parameter int WE_LEN = 2
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        req_we,
  input  logic [23:0] req_addr,
  input  logic [31:0] req_din,
  input  logic [1:0]  req_size,
  output logic        busy,
  output logic        done,
  output logic [23:0] ram_addr,
  output logic [15:0] ram_din,
  output logic        ram_we,
  output logic [1:0]  ram_dsn
);

  typedef enum logic [1:0] {IDLE, SETUP, HOLD} state_t;

  localparam logic [2:0] CNT_LAST = 3'(WE_LEN - 1);

  state_t      st, st_nx;
  logic [23:0] cur;
  logic [31:0] shift;
  logic [2:0]  rem, rem_after, cnt;
  logic [1:0]  cons;
  logic        armed;
  logic        accept, byte_acc, hold_last;

  always_comb begin
    accept    = (st == IDLE) && req_we && armed;
    byte_acc  = cur[0] || (rem == 3'd1);
    hold_last = (cnt == CNT_LAST);
    rem_after = rem - {1'b0, cons};
    st_nx     = st;
    case (st)
      IDLE:    if (accept) st_nx = SETUP;
      SETUP:   st_nx = HOLD;
      HOLD:    if (hold_last) st_nx = (rem_after == 3'd0) ? IDLE : SETUP;
      default: st_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     st <= IDLE;
    else if (cen) st <= st_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      ram_we   <= 1'b0;
      ram_dsn  <= 2'b11;
      ram_addr <= 24'd0;
      ram_din  <= 16'd0;
      cur      <= 24'd0;
      shift    <= 32'd0;
      rem      <= 3'd0;
      cnt      <= 3'd0;
      cons     <= 2'd0;
      armed    <= 1'b1;
    end else begin
      // done is a single clk pulse regardless of cen
      done <= 1'b0;
      if (cen) begin
        case (st)
          IDLE: begin
            if (accept) begin
              cur   <= req_addr;
              shift <= req_din;
              case (req_size)
                2'b01:   rem <= 3'd2;
                2'b10:   rem <= 3'd4;
                default: rem <= 3'd1;
              endcase
              busy  <= 1'b1;
              armed <= 1'b0;
            end else if (!req_we) begin
              armed <= 1'b1;
            end
          end
          SETUP: begin
            ram_addr <= {cur[23:1], 1'b0};
            ram_we   <= 1'b1;
            cnt      <= 3'd0;
            if (byte_acc) begin
              cons    <= 2'd1;
              ram_dsn <= cur[0] ? 2'b01 : 2'b10;
              ram_din <= {shift[7:0], shift[7:0]};
            end else begin
              cons    <= 2'd2;
              ram_dsn <= 2'b00;
              ram_din <= shift[15:0];
            end
          end
          HOLD: begin
            if (hold_last) begin
              ram_we  <= 1'b0;
              ram_dsn <= 2'b11;
              shift   <= (cons == 2'd2) ? (shift >> 16) : (shift >> 8);
              cur     <= cur + {22'd0, cons};
              rem     <= rem_after;
              if (rem_after == 3'd0) begin
                busy <= 1'b0;
                done <= 1'b1;
              end
            end else begin
              cnt <= cnt + 3'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jt900h_ramwr.sv
// Directed bench for jt900h_ramwr: records each RAM access and checks it
// against hand-computed addresses, lanes, data and timing.
module tb_jt900h_ramwr;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cen = 1'b1;
  logic        req_we = 1'b0;
  logic [23:0] req_addr = 24'd0;
  logic [31:0] req_din = 32'd0;
  logic [1:0]  req_size = 2'd0;
  logic        busy, done, ram_we;
  logic [23:0] ram_addr;
  logic [15:0] ram_din;
  logic [1:0]  ram_dsn;

  jt900h_ramwr #(.WE_LEN(2)) dut (
    .clk(clk), .rst(rst), .cen(cen), .req_we(req_we), .req_addr(req_addr),
    .req_din(req_din), .req_size(req_size), .busy(busy), .done(done),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dsn(ram_dsn)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit tog = 1'b0;
  int cen_cyc = 0;

  always begin
    @(posedge clk);
    #1;
    cen = tog ? ~cen : 1'b1;
  end

  always @(posedge clk) if (cen) cen_cyc <= cen_cyc + 1;

  // access recorder
  logic [23:0] addr_q[$];
  logic [15:0] din_q[$];
  logic [1:0]  dsn_q[$];
  int          wlen_q[$];
  logic [23:0] a_s;
  logic [15:0] d_s;
  logic [1:0]  s_s;
  int t_s = 0, done_n = 0, done_at = 0, done_wide = 0, glitch = 0;
  logic we_d = 1'b0, done_d = 1'b0;

  always @(negedge clk) begin
    if (ram_we && !we_d) begin
      a_s = ram_addr; d_s = ram_din; s_s = ram_dsn; t_s = cen_cyc;
    end else if (ram_we && we_d && (ram_addr !== a_s || ram_din !== d_s || ram_dsn !== s_s)) begin
      glitch++;
    end
    if (!ram_we && we_d) begin
      addr_q.push_back(a_s); din_q.push_back(d_s); dsn_q.push_back(s_s);
      wlen_q.push_back(cen_cyc - t_s);
    end
    if (done) begin
      done_n++;
      done_at = cen_cyc;
      if (done_d) done_wide++;
    end
    we_d = ram_we;
    done_d = done;
  end

  int acc_at = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk_acc(input string tag, input int i, input logic [23:0] a,
                         input logic [15:0] d, input logic [1:0] s);
    if (i < addr_q.size()) begin
      chk({tag, "_addr"}, {8'd0, addr_q[i]}, {8'd0, a});
      chk({tag, "_din"},  {16'd0, din_q[i]}, {16'd0, d});
      chk({tag, "_dsn"},  {30'd0, dsn_q[i]}, {30'd0, s});
      chk({tag, "_wlen"}, wlen_q[i], 2);
    end else begin
      chk({tag, "_present"}, 0, 1);
    end
  endtask

  task automatic issue(input logic [23:0] a, input logic [31:0] d,
                       input logic [1:0] s, input bit hold);
    bit ok;
    req_we = 1'b0;
    tick(3);
    addr_q.delete(); din_q.delete(); dsn_q.delete(); wlen_q.delete();
    req_addr = a; req_din = d; req_size = s; req_we = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (busy) begin ok = 1'b1; break; end
    end
    chk("accept", {31'd0, ok}, 32'd1);
    acc_at = cen_cyc;
    if (!hold) req_we = 1'b0;
  endtask

  task automatic wait_done(input int max, input int lat);
    bit ok;
    int base;
    base = done_n;
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (done_n != base) begin ok = 1'b1; break; end
    end
    chk("done_seen", {31'd0, ok}, 32'd1);
    chk("latency", done_at - acc_at, lat);
    @(posedge clk);
    #1;
  endtask

  int base_n;

  initial begin
    // reset state
    tick(2);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_we",   {31'd0, ram_we}, 0);
    chk("rst_dsn",  {30'd0, ram_dsn}, 32'h3);
    chk("rst_addr", {8'd0, ram_addr}, 0);
    chk("rst_din",  {16'd0, ram_din}, 0);
    rst = 1'b1;
    tick(2);

    // byte write at odd address
    issue(24'h00CAFF, 32'h000000A5, 2'b00, 1'b0);
    wait_done(40, 3);
    chk("byte_n", addr_q.size(), 1);
    chk_acc("byte", 0, 24'h00CAFE, 16'hA5A5, 2'b01);

    // aligned long
    issue(24'h001000, 32'h11223344, 2'b10, 1'b0);
    wait_done(60, 6);
    chk("long_n", addr_q.size(), 2);
    chk_acc("long0", 0, 24'h001000, 16'h3344, 2'b00);
    chk_acc("long1", 1, 24'h001002, 16'h1122, 2'b00);

    // odd long: byte, half, byte
    issue(24'h001001, 32'h11223344, 2'b10, 1'b0);
    wait_done(60, 9);
    chk("olong_n", addr_q.size(), 3);
    chk_acc("olong0", 0, 24'h001000, 16'h4444, 2'b01);
    chk_acc("olong1", 1, 24'h001002, 16'h2233, 2'b00);
    chk_acc("olong2", 2, 24'h001004, 16'h1111, 2'b10);

    // word straddling the top of the address space
    issue(24'hFFFFFF, 32'h0000BEEF, 2'b01, 1'b0);
    wait_done(60, 6);
    chk("wrap_n", addr_q.size(), 2);
    chk_acc("wrap0", 0, 24'hFFFFFE, 16'hEFEF, 2'b01);
    chk_acc("wrap1", 1, 24'h000000, 16'hBEBE, 2'b10);

    // held req_we must not retrigger
    issue(24'h000010, 32'h0000005A, 2'b00, 1'b1);
    base_n = done_n;
    wait_done(40, 3);
    tick(10);
    chk("held_done", done_n, base_n + 1);
    chk("held_n", addr_q.size(), 1);
    chk("held_busy", {31'd0, busy}, 0);

    // 50% cen, request inputs scrambled while busy
    tog = 1'b1;
    issue(24'h002001, 32'hAABBCCDD, 2'b10, 1'b1);
    req_addr = 24'h123456; req_din = 32'hFFFFFFFF; req_size = 2'b01;
    wait_done(120, 9);
    req_we = 1'b0;
    chk("cen_n", addr_q.size(), 3);
    chk_acc("cen0", 0, 24'h002000, 16'hDDDD, 2'b01);
    chk_acc("cen1", 1, 24'h002002, 16'hBBCC, 2'b00);
    chk_acc("cen2", 2, 24'h002004, 16'hAAAA, 2'b10);
    tog = 1'b0;
    tick(2);

    // reset during HOLD of the second access
    issue(24'h003000, 32'h01020304, 2'b10, 1'b0);
    tick(5);
    chk("mid_we", {31'd0, ram_we}, 1);
    chk("mid_addr", {8'd0, ram_addr}, 32'h003002);
    base_n = done_n;
    rst = 1'b0;
    #1;
    chk("abort_we", {31'd0, ram_we}, 0);
    chk("abort_dsn", {30'd0, ram_dsn}, 32'h3);
    chk("abort_busy", {31'd0, busy}, 0);
    tick(3);
    rst = 1'b1;
    tick(6);
    chk("abort_nodone", done_n, base_n);

    // size 11 behaves as byte
    issue(24'h000100, 32'h00000077, 2'b11, 1'b0);
    wait_done(40, 3);
    chk("post_n", addr_q.size(), 1);
    chk_acc("post", 0, 24'h000100, 16'h7777, 2'b10);

    chk("stable_strobe", glitch, 0);
    chk("done_width", done_wide, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/jt900h_ramwr.md
Name: jt900h_ramwr

Overview:
- Write-side companion to the CPU RAM read controller (jt900h_ramctl).
- Accepts one CPU write of a byte, word or long at any byte address.
- Splits the write into 16-bit RAM write cycles with per-lane strobes, using TLCS-900 little-endian lane mapping: the even byte goes on bits 7:0 and the odd byte on bits 15:8.
- Signals completion to the requester with a single done pulse.

Parameters:
- WE_LEN, default 2: number of cen-qualified cycles that ram_we stays high per RAM access (range 1..7).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, active-low, asynchronous; all state clears while rst=0.
- cen  input  1  clock enable; the FSM advances only on clk edges with cen=1.
- req_we  input  1  write request, level-sensitive.
- req_addr  input  24  byte address of the first byte.
- req_din  input  32  write data; bits 7:0 go to req_addr, 15:8 to req_addr+1, and so on.
- req_size  input  2  00 byte, 01 word, 10 long; 11 is treated as byte.
- busy  output  1  high from acceptance until the last access finishes.
- done  output  1  single-clk pulse at completion.
- ram_addr  output  24  halfword address; bit 0 is always 0.
- ram_din  output  16  RAM write data.
- ram_we  output  1  RAM write strobe, active high.
- ram_dsn  output  2  lane strobes, active low; bit 0 is lane 7:0, bit 1 is lane 15:8.

Behaviour:
- Reset values: busy=0, done=0, ram_we=0, ram_dsn=2'b11, ram_addr=0, ram_din=0, FSM=IDLE, armed=1.
- Reset while a write is in progress aborts it immediately; no done pulse is produced.
- States:
  - IDLE: on a cen cycle with req_we=1 and armed=1, latch the request and go to SETUP.
    - Latched values: cur=req_addr, shift=req_din, rem = 1, 2 or 4 bytes.
    - On the same cycle set busy=1 and armed=0.
    - armed returns to 1 on any cen cycle in IDLE with req_we=0. A held req_we therefore never causes a second write.
  - SETUP (1 cen cycle): choose the access type.
    - Byte access if cur[0]=1 or rem=1:
      - lane = cur[0]; ram_dsn = 2'b01 when cur[0]=1, 2'b10 when cur[0]=0;
      - ram_din = {shift[7:0], shift[7:0]};
      - consumes 1 byte.
    - Otherwise halfword access:
      - ram_dsn = 2'b00; ram_din = shift[15:0];
      - consumes 2 bytes.
    - In both cases ram_addr = {cur[23:1], 1'b0}.
    - Set ram_we=1 and go to HOLD.
  - HOLD: ram_we stays high for WE_LEN cen cycles, with address, data and strobes stable.
    - On the last cycle: ram_we=0, ram_dsn=2'b11; shift right by the consumed bytes times 8; cur += consumed (modulo 2^24, so 0xFFFFFF+1 wraps to 0); rem -= consumed.
    - If rem=0, go to IDLE, busy=0, done=1 for exactly one clk. Otherwise go to SETUP.
- Access counts:
  - byte: 1 access.
  - word, even address: 1 access. Word, odd address: 2 accesses (byte, byte).
  - long, even address: 2 accesses (half, half). Long, odd address: 3 accesses (byte, half, byte).
- Latency: acceptance-to-done is accesses × (WE_LEN+1) cen cycles.
- cen=0: all registers and outputs hold. done still falls after one clk.
- Request inputs are ignored while busy=1 and may change freely once accepted.
- ram_addr, ram_din and ram_dsn change only while ram_we=0, so there are no glitches during a strobe.

Test Plan:
- Byte write: req_addr=0x00CAFF, size=00, din=0x000000A5, WE_LEN=2 → one access with ram_addr=0x00CAFE, ram_dsn=01, ram_din=0xA5A5, ram_we high for 2 cycles; done 3 cen cycles after acceptance.
- Aligned long write: req_addr=0x001000, din=0x11223344 → 0x001000 dsn=00 din=0x3344, then 0x001002 din=0x1122; done after 6 cycles.
- Odd long write: req_addr=0x001001, din=0x11223344 → 0x001000 dsn=01 din=0x4444; 0x001002 dsn=00 din=0x2233; 0x001004 dsn=10 din=0x1111; 3 accesses total.
- Wrap: req_addr=0xFFFFFF, word write, din=0xBEEF → 0xFFFFFE dsn=01 din=0xEFEF, then 0x000000 dsn=10 din=0xBEBE.
- Handshake and cen:
  - Hold req_we high across done → no second write until req_we is low for one cen cycle.
  - Toggle cen at 50% → identical access sequence, each phase stretched accordingly.
  - Changing req_* while busy → no effect on the write in progress.
- Reset mid-operation: drop rst during HOLD of access 2 of a long write → ram_we=0, ram_dsn=11, busy=0 immediately, no done pulse. After release, a new byte write completes normally.
